// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between the execute stage and the data memory port.
// One operation at a time is accepted over a valid/ready handshake, sent to memory
// as a word-aligned request with byte mask, and loads come back lane-shifted and
// sign/zero-extended to 32 bits.
// Optional build macro: LSU_MISALIGN_TRAP_EN -- misaligned half/word accesses and
// undefined mem_op codes skip the memory request and complete with out_err=1.
module lsu_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_we,
    input  logic [2:0]        in_ctr,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rdata,
    output logic              out_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_wmask,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t              state, state_nxt;
    logic                op_we;
    logic [2:0]          op_ctr;
    logic [ADDR_W-1:0]   op_addr;
    logic [DATA_W-1:0]   op_wd;
    logic [DATA_W-1:0]   res_rdata;
    logic                accept;
    logic                take_trap;
    logic                op_byte;
    logic                op_half;
    logic [4:0]          shamt;
    logic [DATA_W-1:0]   lane;
    logic [DATA_W-1:0]   load_val;

    assign accept = in_valid && (state == IDLE);

    // Undefined codes (011, 110, 111) fall through to word size.
    assign op_byte = (op_ctr[1:0] == 2'b00);
    assign op_half = (op_ctr[1:0] == 2'b01);

`ifdef LSU_MISALIGN_TRAP_EN
    logic in_undef;
    logic in_half;
    logic in_word;
    logic res_err;

    assign in_undef  = (in_ctr == 3'b011) || (in_ctr == 3'b110) || (in_ctr == 3'b111);
    assign in_half   = (in_ctr[1:0] == 2'b01);
    assign in_word   = (in_ctr == 3'b010);
    assign take_trap = in_undef || (in_half && in_addr[0]) || (in_word && (in_addr[1:0] != 2'b00));
    assign out_err   = res_err;

    // Error flag is decided at accept time and held through DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_err <= 1'b0;
        end else if (accept) begin
            res_err <= take_trap;
        end
    end
`else
    assign take_trap = 1'b0;
    assign out_err   = 1'b0;
`endif

    // Next-state logic for the four-phase handshake sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = take_trap ? DONE : REQ;
            REQ:  if (mem_req_ready) state_nxt = WAIT;
            WAIT: if (mem_resp_valid) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready      = (state == IDLE);
    assign out_valid     = (state == DONE);
    assign mem_req_valid = (state == REQ);
    assign out_rdata     = res_rdata;

    // Request fields come from the latched operation and are only driven while in REQ.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wmask = 4'b0000;
        mem_wdata = '0;
        if (state == REQ) begin
            mem_addr = {op_addr[ADDR_W-1:2], 2'b00};
            mem_we   = op_we;
            if (op_we) begin
                if (op_byte) begin
                    mem_wmask = 4'b0001 << op_addr[1:0];
                    mem_wdata = {4{op_wd[7:0]}};
                end else if (op_half) begin
                    mem_wmask = 4'b0011 << {op_addr[1], 1'b0};
                    mem_wdata = {2{op_wd[15:0]}};
                end else begin
                    mem_wmask = 4'b1111;
                    mem_wdata = op_wd;
                end
            end
        end
    end

    // Lane-shift the returned word and extend according to size and signedness.
    always_comb begin
        shamt = 5'd0;
        if (op_byte) begin
            shamt = {op_addr[1:0], 3'b000};
        end else if (op_half) begin
            shamt = {op_addr[1], 4'b0000};
        end
        lane = mem_rdata >> shamt;
        if (op_byte) begin
            load_val = {{24{~op_ctr[2] & lane[7]}}, lane[7:0]};
        end else if (op_half) begin
            load_val = {{16{~op_ctr[2] & lane[15]}}, lane[15:0]};
        end else begin
            load_val = lane;
        end
    end

    // State register, operation latch and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_we     <= 1'b0;
            op_ctr    <= 3'b000;
            op_addr   <= '0;
            op_wd     <= '0;
            res_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_we     <= in_we;
                op_ctr    <= in_ctr;
                op_addr   <= in_addr;
                op_wd     <= in_wd;
                res_rdata <= '0;
            end else if ((state == WAIT) && mem_resp_valid) begin
                res_rdata <= op_we ? '0 : load_val;
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: directed cases plus randomized operations with random
// memory and consumer stalls, checked against a behavioural model of the unit.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_we;
    logic [2:0]  in_ctr;
    logic [31:0] in_addr;
    logic [31:0] in_wd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        out_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    int tests_run;
    int tests_failed;

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_ctr(in_ctr),
        .in_addr(in_addr), .in_wd(in_wd),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Reference behaviour: what memory should see and what the consumer should get.
    function automatic void model(input logic we, input logic [2:0] ctr, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [31:0] rdata,
                                  output logic [31:0] e_addr, output logic [31:0] e_mask,
                                  output logic [31:0] e_wdata, output logic [31:0] e_rdata,
                                  output logic e_trap);
        int bytes;
        int off;
        logic [63:0] m;
        logic [63:0] v;
        bytes = (ctr == 3'd0 || ctr == 3'd4) ? 1 : (ctr == 3'd1 || ctr == 3'd5) ? 2 : 4;
        off = (bytes == 1) ? int'(addr[1:0]) : (bytes == 2) ? (addr[1] ? 2 : 0) : 0;
        e_addr = {addr[31:2], 2'b00};
        e_mask = we ? 32'(((1 << bytes) - 1) << off) : 32'd0;
        if (!we) e_wdata = 32'd0;
        else if (bytes == 1) e_wdata = {24'd0, wd[7:0]} * 32'h01010101;
        else if (bytes == 2) e_wdata = {16'd0, wd[15:0]} * 32'h00010001;
        else e_wdata = wd;
        m = (64'd1 << (8 * bytes)) - 64'd1;
        v = ({32'd0, rdata} >> (8 * off)) & m;
        if (!ctr[2] && bytes < 4 && v[8 * bytes - 1]) v = v | ~m;
        e_rdata = we ? 32'd0 : v[31:0];
`ifdef LSU_MISALIGN_TRAP_EN
        e_trap = (ctr == 3'd3) || (ctr >= 3'd6) || (bytes == 2 && addr[0]) || (bytes == 4 && addr[1:0] != 2'b00);
`else
        e_trap = 1'b0;
`endif
        if (e_trap) e_rdata = 32'd0;
    endfunction

    // Run one full operation; called just after a falling edge, returns just after one.
    task automatic applyStimulus(input logic we, input logic [2:0] ctr, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] rdata,
                                 input int req_wait, input int resp_wait, input int out_wait);
        logic [31:0] e_addr, e_mask, e_wdata, e_rdata;
        logic        e_trap;
        model(we, ctr, addr, wd, rdata, e_addr, e_mask, e_wdata, e_rdata, e_trap);
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_we = we; in_ctr = ctr; in_addr = addr; in_wd = wd;
        mem_resp_valid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        @(negedge clk);
        in_valid = 1'b0; in_we = 1'($urandom_range(0, 1)); in_ctr = 3'($urandom_range(0, 7));
        in_addr = $urandom; in_wd = $urandom;
        if (!e_trap) begin
            for (int i = 0; i <= req_wait; i++) begin
                checkOutput("req_valid", 32'(mem_req_valid), 32'd1);
                checkOutput("req_addr", mem_addr, e_addr);
                checkOutput("req_we", 32'(mem_we), 32'(we));
                checkOutput("req_wmask", 32'(mem_wmask), e_mask);
                checkOutput("req_wdata", mem_wdata, e_wdata);
                checkOutput("req_busy", 32'(in_ready), 32'd0);
                checkOutput("req_no_out", 32'(out_valid), 32'd0);
                mem_req_ready = (i == req_wait);
                mem_resp_valid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
                @(negedge clk);
            end
            mem_req_ready = 1'b0;
            for (int j = 0; j <= resp_wait; j++) begin
                checkOutput("wait_no_req", 32'(mem_req_valid), 32'd0);
                checkOutput("wait_no_out", 32'(out_valid), 32'd0);
                checkOutput("wait_busy", 32'(in_ready), 32'd0);
                mem_resp_valid = (j == resp_wait);
                mem_rdata = (j == resp_wait) ? rdata : $urandom;
                @(negedge clk);
            end
        end else begin
            checkOutput("trap_no_req", 32'(mem_req_valid), 32'd0);
        end
        for (int k = 0; k <= out_wait; k++) begin
            checkOutput("done_valid", 32'(out_valid), 32'd1);
            checkOutput("done_rdata", out_rdata, e_rdata);
            checkOutput("done_err", 32'(out_err), 32'(e_trap));
            checkOutput("done_busy", 32'(in_ready), 32'd0);
            checkOutput("done_no_req", 32'(mem_req_valid), 32'd0);
            out_ready = (k == out_wait);
            mem_resp_valid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
            @(negedge clk);
        end
        out_ready = 1'b0;
        mem_resp_valid = 1'b0;
        checkOutput("back_idle", 32'(out_valid), 32'd0);
    endtask

    function automatic int randWait();
        if ($urandom_range(0, 1) == 0) return 0;
        return int'($urandom_range(0, 4));
    endfunction

    initial begin
        logic [2:0] ctr;
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        in_valid = 1'b0; in_we = 1'b0; in_ctr = 3'd0; in_addr = 32'd0; in_wd = 32'd0;
        out_ready = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'd0;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_rdata", out_rdata, 32'd0);
        checkOutput("rst_out_err", 32'(out_err), 32'd0);
        checkOutput("rst_req_valid", 32'(mem_req_valid), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_wmask", 32'(mem_wmask), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases from the test plan.
        applyStimulus(1'b0, 3'b000, 32'h80000003, 32'h0, 32'h8A000000, 0, 0, 0);
        applyStimulus(1'b0, 3'b101, 32'h80000002, 32'h0, 32'hBEEF1234, 0, 0, 0);
        applyStimulus(1'b0, 3'b001, 32'h80000002, 32'h0, 32'hBEEF1234, 0, 1, 0);
        applyStimulus(1'b1, 3'b000, 32'h00001001, 32'h000000AB, 32'h12345678, 0, 2, 0);
        applyStimulus(1'b0, 3'b010, 32'h00004000, 32'h0, 32'hCAFEF00D, 5, 0, 3);
        applyStimulus(1'b0, 3'b010, 32'h00001002, 32'h0, 32'h01020304, 0, 0, 0);
        applyStimulus(1'b1, 3'b001, 32'h00002003, 32'h0000BEEF, 32'h0, 1, 1, 1);

        // Reset while waiting for the response, then a late response arrives.
        in_valid = 1'b1; in_we = 1'b0; in_ctr = 3'b010; in_addr = 32'h00002000;
        @(negedge clk);
        in_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_req", 32'(mem_req_valid), 32'd0);
        checkOutput("mid_rst_out", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_addr", mem_addr, 32'd0);
        checkOutput("mid_rst_rdata", out_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        checkOutput("late_resp_out", 32'(out_valid), 32'd0);
        checkOutput("late_resp_req", 32'(mem_req_valid), 32'd0);
        checkOutput("late_resp_rdata", out_rdata, 32'd0);
        applyStimulus(1'b0, 3'b010, 32'h00003000, 32'h0, 32'h55AA33CC, 0, 0, 0);

        // Randomized operations with random stalls on both sides.
        for (int n = 0; n < 300; n++) begin
            ctr = 3'($urandom_range(0, 7));
            applyStimulus(1'($urandom_range(0, 1)), ctr, $urandom, $urandom, $urandom,
                          randWait(), randWait(), randWait());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
